// File: rtl/ascon_output_serializer.sv
// Buffers ascon cipher words and the final tag, then re-emits them as one ordered
// 64-bit valid/ready stream: cipher words, tag[127:64], tag[63:0] (last).
module ascon_output_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       i_sys_enable,
    input  logic                       i_valid_cipher,
    input  logic [63:0]                i_cipher,
    input  logic                       i_done,
    input  logic [127:0]               i_tag,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic [63:0]                o_data,
    output logic                       o_kind,
    output logic                       o_last,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_busy,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {ST_CIPHER, ST_TAG_HI, ST_TAG_LO} state_t;

    state_t         state;
    state_t         state_next;
    logic [63:0]    mem [DEPTH];
    logic [LW-1:0]  wr_ptr;
    logic [LW-1:0]  rd_ptr;
    logic [LW-1:0]  level;
    logic [LW-1:0]  level_next;
    logic [127:0]   tag_reg;
    logic           tag_pending;
    logic           tag_pending_next;
    logic           overflow;
    logic           empty;
    logic           full;
    logic           beat;
    logic           pop;
    logic           push;
    logic           cipher_drop;
    logic           tag_take;
    logic           tag_drop;
    logic           tag_release;

    // Pointers carry one wrap bit so full and empty are distinguishable
    assign level = wr_ptr - rd_ptr;
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        o_kind  = 1'b0;
        o_last  = 1'b0;
        case (state)
            ST_CIPHER: begin
                o_valid = !empty;
                o_data  = empty ? 64'd0 : mem[rd_ptr[AW-1:0]];
            end
            ST_TAG_HI: begin
                o_valid = 1'b1;
                o_data  = tag_reg[127:64];
                o_kind  = 1'b1;
            end
            ST_TAG_LO: begin
                o_valid = 1'b1;
                o_data  = tag_reg[63:0];
                o_kind  = 1'b1;
                o_last  = 1'b1;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

    assign beat        = o_valid & i_ready;
    assign pop         = beat & (state == ST_CIPHER);
    assign push        = i_valid_cipher & (!full | pop);
    assign cipher_drop = i_valid_cipher & full & !pop;
    assign tag_take    = i_done & !tag_pending;
    assign tag_drop    = i_done & tag_pending;
    assign tag_release = beat & (state == ST_TAG_LO);

    assign tag_pending_next = (tag_pending & !tag_release) | tag_take;
    assign level_next       = level + LW'(push) - LW'(pop);

    // Tag emission starts only once the FIFO drains, judged on post-update occupancy
    always_comb begin
        state_next = state;
        case (state)
            ST_CIPHER: if (tag_pending_next && (level_next == '0)) state_next = ST_TAG_HI;
            ST_TAG_HI: if (beat) state_next = ST_TAG_LO;
            ST_TAG_LO: if (beat) state_next = ST_CIPHER;
            default:   state_next = ST_CIPHER;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_CIPHER;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_pending <= 1'b0;
            overflow    <= 1'b0;
        end else if (i_sys_enable) begin
            state       <= state_next;
            tag_pending <= tag_pending_next;
            if (push)                   wr_ptr   <= wr_ptr + LW'(1);
            if (pop)                    rd_ptr   <= rd_ptr + LW'(1);
            if (cipher_drop | tag_drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (i_sys_enable) begin
            if (push)     mem[wr_ptr[AW-1:0]] <= i_cipher;
            if (tag_take) tag_reg             <= i_tag;
        end
    end

    assign o_level    = level;
    assign o_busy     = !empty | tag_pending;
    assign o_overflow = overflow;

endmodule

// File: tb/tb_ascon_output_serializer.sv
// Directed bench for ascon_output_serializer: beats are logged by a monitor and
// compared against hand-built expected streams.
module tb_ascon_output_serializer;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         i_sys_enable;
    logic         i_valid_cipher;
    logic [63:0]  i_cipher;
    logic         i_done;
    logic [127:0] i_tag;
    logic         i_ready;
    logic         o_valid;
    logic [63:0]  o_data;
    logic         o_kind;
    logic         o_last;
    logic [2:0]   o_level;
    logic         o_busy;
    logic         o_overflow;

    int n_vec = 0;
    int n_bad = 0;

    logic [65:0] beats[$];
    logic [65:0] exp_q[$];

    always #5 clock = ~clock;

    ascon_output_serializer #(.DEPTH(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_sys_enable   (i_sys_enable),
        .i_valid_cipher (i_valid_cipher),
        .i_cipher       (i_cipher),
        .i_done         (i_done),
        .i_tag          (i_tag),
        .i_ready        (i_ready),
        .o_valid        (o_valid),
        .o_data         (o_data),
        .o_kind         (o_kind),
        .o_last         (o_last),
        .o_level        (o_level),
        .o_busy         (o_busy),
        .o_overflow     (o_overflow)
    );

    // Inputs change only at #1 after the rising edge, so this view holds through the next edge
    always @(negedge clock)
        if (reset_n && i_sys_enable && o_valid && i_ready)
            beats.push_back({o_kind, o_last, o_data});

    task automatic check(input string tag, input logic [65:0] got, input logic [65:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_cipher(input logic [63:0] w);
        i_valid_cipher = 1'b1;
        i_cipher       = w;
        step();
        i_valid_cipher = 1'b0;
    endtask

    task automatic pulse_done(input logic [127:0] t);
        i_done = 1'b1;
        i_tag  = t;
        step();
        i_done = 1'b0;
    endtask

    task automatic want_beat(input logic kind, input logic last, input logic [63:0] data);
        exp_q.push_back({kind, last, data});
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (beats.size() < exp_q.size() && t < 60) begin
            step();
            t++;
        end
        step(4);
        check({tag, "_count"}, 66'(beats.size()), 66'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < beats.size())
                check($sformatf("%s_beat%0d", tag, i), beats[i], exp_q[i]);
        beats.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n        = 1'b0;
        i_sys_enable   = 1'b1;
        i_valid_cipher = 1'b0;
        i_cipher       = '0;
        i_done         = 1'b0;
        i_tag          = '0;
        i_ready        = 1'b0;
        step(2);

        // Reset state
        check("rst_valid",    66'(o_valid),    66'd0);
        check("rst_data",     66'(o_data),     66'd0);
        check("rst_kind",     66'(o_kind),     66'd0);
        check("rst_last",     66'(o_last),     66'd0);
        check("rst_level",    66'(o_level),    66'd0);
        check("rst_busy",     66'(o_busy),     66'd0);
        check("rst_overflow", 66'(o_overflow), 66'd0);
        reset_n = 1'b1;
        step();

        // Basic message, consumer always ready
        i_ready = 1'b1;
        pulse_cipher(64'h1111_1111_1111_1111);
        pulse_cipher(64'h2222_2222_2222_2222);
        pulse_cipher(64'h3333_3333_3333_3333);
        pulse_done(128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB);
        want_beat(1'b0, 1'b0, 64'h1111_1111_1111_1111);
        want_beat(1'b0, 1'b0, 64'h2222_2222_2222_2222);
        want_beat(1'b0, 1'b0, 64'h3333_3333_3333_3333);
        want_beat(1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA);
        want_beat(1'b1, 1'b1, 64'hBBBB_BBBB_BBBB_BBBB);
        drain("basic");
        check("basic_busy",     66'(o_busy),     66'd0);
        check("basic_overflow", 66'(o_overflow), 66'd0);

        // Back-pressure and FIFO overflow
        i_ready = 1'b0;
        pulse_cipher(64'hD000_0000_0000_0001);
        pulse_cipher(64'hD000_0000_0000_0002);
        pulse_cipher(64'hD000_0000_0000_0003);
        pulse_cipher(64'hD000_0000_0000_0004);
        check("full_level", 66'(o_level), 66'd4);
        check("full_head",  66'(o_data),  66'hD000_0000_0000_0001);
        pulse_cipher(64'hD000_0000_0000_0005);
        check("ovf_level", 66'(o_level),    66'd4);
        check("ovf_flag",  66'(o_overflow), 66'd1);
        check("ovf_head",  66'(o_data),     66'hD000_0000_0000_0001);
        check("ovf_valid", 66'(o_valid),    66'd1);
        pulse_done(128'h3C3C_3C3C_3C3C_3C3C_C3C3_C3C3_C3C3_C3C3);
        i_ready = 1'b1;
        want_beat(1'b0, 1'b0, 64'hD000_0000_0000_0001);
        want_beat(1'b0, 1'b0, 64'hD000_0000_0000_0002);
        want_beat(1'b0, 1'b0, 64'hD000_0000_0000_0003);
        want_beat(1'b0, 1'b0, 64'hD000_0000_0000_0004);
        want_beat(1'b1, 1'b0, 64'h3C3C_3C3C_3C3C_3C3C);
        want_beat(1'b1, 1'b1, 64'hC3C3_C3C3_C3C3_C3C3);
        drain("bp");

        // Reset in the middle of tag emission
        i_ready = 1'b0;
        pulse_done(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        check("mid_tag_kind",  66'(o_kind), 66'd1);
        check("mid_tag_data",  66'(o_data), 66'h0123_4567_89AB_CDEF);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid",    66'(o_valid),    66'd0);
        check("mid_rst_busy",     66'(o_busy),     66'd0);
        check("mid_rst_overflow", 66'(o_overflow), 66'd0);
        step();
        reset_n = 1'b1;
        step();

        // Same-cycle cipher and done: cipher goes first
        i_ready        = 1'b1;
        i_valid_cipher = 1'b1;
        i_cipher       = 64'h5555_5555_5555_5555;
        i_done         = 1'b1;
        i_tag          = 128'h7777_7777_7777_7777_8888_8888_8888_8888;
        step();
        i_valid_cipher = 1'b0;
        i_done         = 1'b0;
        want_beat(1'b0, 1'b0, 64'h5555_5555_5555_5555);
        want_beat(1'b1, 1'b0, 64'h7777_7777_7777_7777);
        want_beat(1'b1, 1'b1, 64'h8888_8888_8888_8888);
        drain("same");
        check("same_overflow", 66'(o_overflow), 66'd0);

        // Second done while tag pending; cipher arriving during the tag_lo beat
        i_ready = 1'b0;
        pulse_done(128'h1234_0000_0000_0001_5678_0000_0000_0002);
        check("t5_hi_data", 66'(o_data), 66'h1234_0000_0000_0001);
        pulse_done(128'hEEEE_EEEE_EEEE_EEEE_FFFF_FFFF_FFFF_FFFF);
        check("t5_overflow", 66'(o_overflow), 66'd1);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        check("t5_lo_last", 66'(o_last), 66'd1);
        check("t5_lo_data", 66'(o_data), 66'h5678_0000_0000_0002);
        pulse_cipher(64'hC5C5_C5C5_C5C5_C5C5);
        check("t5_lo_level", 66'(o_level), 66'd1);
        check("t5_lo_hold",  66'(o_data),  66'h5678_0000_0000_0002);
        i_ready = 1'b1;
        want_beat(1'b1, 1'b0, 64'h1234_0000_0000_0001);
        want_beat(1'b1, 1'b1, 64'h5678_0000_0000_0002);
        want_beat(1'b0, 1'b0, 64'hC5C5_C5C5_C5C5_C5C5);
        drain("t5");

        // Global enable low freezes everything
        i_ready = 1'b0;
        pulse_cipher(64'h6666_0000_0000_000A);
        pulse_cipher(64'h6666_0000_0000_000B);
        check("en_pre_level", 66'(o_level), 66'd2);
        i_sys_enable = 1'b0;
        i_ready      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            i_valid_cipher = 1'b1;
            i_cipher       = 64'hDEAD_BEEF_0000_0000 | 64'(i);
            i_done         = i[0];
            i_tag          = 128'hBAD0_BAD0_BAD0_BAD0_BAD1_BAD1_BAD1_BAD1;
            step();
        end
        i_valid_cipher = 1'b0;
        i_done         = 1'b0;
        check("en_level", 66'(o_level), 66'd2);
        check("en_head",  66'(o_data),  66'h6666_0000_0000_000A);
        check("en_kind",  66'(o_kind),  66'd0);
        check("en_beats", 66'(beats.size()), 66'd0);
        i_sys_enable = 1'b1;
        pulse_done(128'h9999_9999_9999_9999_0000_0000_0000_0006);
        want_beat(1'b0, 1'b0, 64'h6666_0000_0000_000A);
        want_beat(1'b0, 1'b0, 64'h6666_0000_0000_000B);
        want_beat(1'b1, 1'b0, 64'h9999_9999_9999_9999);
        want_beat(1'b1, 1'b1, 64'h0000_0000_0000_0006);
        drain("en");
        check("en_busy", 66'(o_busy), 66'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
